// File: rtl/gcd_pkg.sv
// gcd_pkg: shared FSM state and algorithm-select types for the gcd_multi engine
package gcd_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} gcd_state_t;
  typedef enum logic {MODE_EUCLID = 1'b0, MODE_BINARY = 1'b1} gcd_mode_t;
endpackage

// File: rtl/gcd_step.sv
// gcd_step: one combinational Euclid/Stein step (a, b, mode -> next_a, next_b, inc_k, term)
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  gcd_mode_t        mode,
  output logic [WIDTH-1:0] next_a,
  output logic [WIDTH-1:0] next_b,
  output logic             inc_k,
  output logic             term
);
  logic [WIDTH-1:0] diff_ab, diff_ba;
  logic euclid, even_a, even_b, a_gt_b, a_ge_b;
  assign diff_ab = a - b;
  assign diff_ba = b - a;
  assign euclid  = mode == MODE_EUCLID;
  assign even_a  = !a[0];
  assign even_b  = !b[0];
  assign a_gt_b  = a > b;
  assign a_ge_b  = a >= b;
  assign term    = a == '0 || b == '0 || (euclid && a == b);
  assign inc_k   = !euclid && even_a && even_b;
  assign next_a  = euclid ? (a_gt_b ? diff_ab : a) :
                   even_a ? a >> 1 :
                   even_b ? a :
                   a_ge_b ? diff_ab >> 1 : a;
  assign next_b  = euclid ? (a_gt_b ? b : diff_ba) :
                   even_b ? b >> 1 :
                   even_a ? b :
                   a_ge_b ? b : diff_ba >> 1;
endmodule

// File: rtl/gcd_multi.sv
// gcd_multi: start/done gcd engine (clk, reset, start, mode, a_in, b_in -> ready, done, result, cycles)
module gcd_multi
  import gcd_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] cycles
);
  localparam int KW = $clog2(WIDTH) + 1;
  gcd_state_t state, state_n;
  gcd_mode_t md;
  logic [WIDTH-1:0] a, b, cnt, cnt_inc, next_a, next_b;
  logic [KW-1:0] k;
  logic inc_k, term;
  gcd_step #(.WIDTH(WIDTH)) u_step (
    .a     (a),
    .b     (b),
    .mode  (md),
    .next_a(next_a),
    .next_b(next_b),
    .inc_k (inc_k),
    .term  (term)
  );
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
  always_comb begin
    state_n = state == IDLE ? (start ? BUSY : IDLE) :
              state == BUSY ? (term ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ready  <= 1'b1;
      done   <= 1'b0;
      result <= '0;
      cycles <= '0;
      a      <= '0;
      b      <= '0;
      cnt    <= '0;
      k      <= '0;
      md     <= MODE_EUCLID;
    end else begin
      state <= state_n;
      ready <= state_n == IDLE;
      done  <= state_n == DONE;
      if (state == IDLE && start) begin
        a   <= a_in;
        b   <= b_in;
        md  <= gcd_mode_t'(mode);
        k   <= '0;
        cnt <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt_inc;
        if (term) begin
          result <= (a | b) << k;
          cycles <= cnt_inc;
        end else begin
          a <= next_a;
          b <= next_b;
          k <= k + KW'(inc_k);
        end
      end
    end
  end
endmodule

// File: tb/tb_gcd_multi.sv
// tb_gcd_multi: directed table, corner sequences and random regression for gcd_multi
module tb_gcd_multi;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic s16 = 1'b0, m16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, res16, cyc16;
  logic r16, dn16;
  logic s8 = 1'b0, m8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, res8, cyc8;
  logic r8, dn8;
  gcd_multi #(.WIDTH(16)) u16 (
    .clk(clk), .reset(reset), .start(s16), .mode(m16), .a_in(a16), .b_in(b16),
    .ready(r16), .done(dn16), .result(res16), .cycles(cyc16)
  );
  gcd_multi #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(s8), .mode(m8), .a_in(a8), .b_in(b8),
    .ready(r8), .done(dn8), .result(res8), .cycles(cyc8)
  );
  typedef struct {
    bit          md;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    int          cyc;
  } vec_t;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", n, got, exp);
    end
  endtask
  function automatic int ref_gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction
  function automatic int ref_euc_cycles(input int a, input int b);
    int s = 0;
    int t;
    if (a == 0 || b == 0) return 1;
    while (b != 0) begin
      s += a / b;
      t = a % b;
      a = b;
      b = t;
    end
    return s;
  endfunction
  task automatic run(input bit w8, input bit md, input logic [15:0] a, input logic [15:0] b,
                     output logic [15:0] res, output logic [15:0] cyc, output int lat);
    int g = 0;
    while (!(w8 ? r8 : r16) && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (w8) begin
      s8 = 1'b1; m8 = md; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      s16 = 1'b1; m16 = md; a16 = a; b16 = b;
    end
    @(negedge clk);
    s8 = 1'b0;
    s16 = 1'b0;
    lat = 1;
    while (!(w8 ? dn8 : dn16) && lat < 70000) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 70000) chk("done_timeout", 0, 1);
    res = w8 ? {8'h00, res8} : res16;
    cyc = w8 ? {8'h00, cyc8} : cyc16;
    @(negedge clk);
    chk("done_one_cycle", w8 ? dn8 : dn16, 1'b0);
    chk("ready_after_done", w8 ? r8 : r16, 1'b1);
    chk("result_held", w8 ? {8'h00, res8} : res16, res);
  endtask
  vec_t tbl[10];
  logic [15:0] res, cyc;
  int lat, n;
  initial begin
    tbl[0] = '{0, 12, 8, 4, 3};
    tbl[1] = '{1, 12, 8, 4, 6};
    tbl[2] = '{0, 1071, 462, 21, 12};
    tbl[3] = '{1, 1071, 462, 21, -1};
    tbl[4] = '{0, 0, 0, 0, 1};
    tbl[5] = '{1, 0, 0, 0, 1};
    tbl[6] = '{0, 0, 9, 9, 1};
    tbl[7] = '{0, 9, 0, 9, 1};
    tbl[8] = '{1, 0, 9, 9, 1};
    tbl[9] = '{1, 9, 0, 9, 1};
    repeat (2) @(negedge clk);
    chk("rst_ready", r16, 1'b1);
    chk("rst_done", dn16, 1'b0);
    chk("rst_result", res16, 0);
    chk("rst_cycles", cyc16, 0);
    reset = 1'b0;
    @(negedge clk);
    foreach (tbl[i]) begin
      run(0, tbl[i].md, tbl[i].a, tbl[i].b, res, cyc, lat);
      chk($sformatf("tbl%0d_result", i), res, tbl[i].res);
      if (tbl[i].cyc >= 0) chk($sformatf("tbl%0d_cycles", i), cyc, tbl[i].cyc);
      chk($sformatf("tbl%0d_latency", i), lat, cyc + 1);
    end
    run(1, 0, 255, 1, res, cyc, lat);
    chk("w8_euclid_result", res, 1);
    chk("w8_euclid_cycles", cyc, 255);
    chk("w8_euclid_latency", lat, 256);
    run(1, 1, 255, 1, res, cyc, lat);
    chk("w8_binary_result", res, 1);
    chk("w8_binary_cycles_le17", cyc <= 17, 1'b1);
    @(negedge clk);
    s16 = 1'b1; m16 = 1'b0; a16 = 12; b16 = 8;
    n = 0;
    for (int g = 0; g < 50; g++) begin
      @(negedge clk);
      if (dn16) begin
        n++;
        break;
      end
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      m16 = 1'($urandom);
    end
    s16 = 1'b0;
    chk("busy_start_result", res16, 4);
    chk("busy_start_cycles", cyc16, 3);
    for (int g = 0; g < 6; g++) begin
      @(negedge clk);
      if (dn16) n++;
    end
    chk("busy_start_done_count", n, 1);
    s16 = 1'b1; m16 = 1'b0; a16 = 1071; b16 = 462;
    @(negedge clk);
    s16 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_ready", r16, 1'b1);
    chk("midrst_done", dn16, 1'b0);
    chk("midrst_result", res16, 0);
    chk("midrst_cycles", cyc16, 0);
    reset = 1'b0;
    run(0, 0, 6, 4, res, cyc, lat);
    chk("after_rst_result", res, 2);
    chk("after_rst_cycles", cyc, 3);
    for (int md = 0; md < 2; md++) begin
      for (int i = 0; i < 400; i++) begin
        logic [15:0] ra, rb;
        do begin
          ra = (i % 50 == 0) ? 16'h0 : 16'($urandom);
          rb = (i % 70 == 1) ? 16'h0 : 16'($urandom);
        end while (md == 0 && ref_euc_cycles(ra, rb) > 300);
        run(0, md[0], ra, rb, res, cyc, lat);
        chk("rand_result", res, ref_gcd(ra, rb));
        if (md == 0) chk("rand_euclid_cycles", cyc, ref_euc_cycles(ra, rb));
        else chk("rand_binary_cycles_le33", cyc <= 33, 1'b1);
        chk("rand_latency", lat, cyc + 1);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gcd_multi.md
# gcd_multi

Parametrised greatest-common-divisor engine, the successor to our fixed 32-bit `gcd` unit. It computes gcd(a, b) for unsigned WIDTH-bit operands with a run-time selectable algorithm: subtractive Euclid or binary (Stein). It uses the same start/done handshake as `gcd` and adds a ready flag and an iteration count for performance characterisation. It sits behind a sequencer or bench that presents one operand pair per transaction.

## Interface
- WIDTH, 32, operand and result width in bits (≥ 2).
- clk  input  1  rising-edge clock; the block uses only this clock.
- reset  input  1  reset; synchronous and active-high.
- start  input  1  one-cycle request; sampled only when ready=1.
- mode  input  1  0 = Euclid (subtractive), 1 = binary (Stein); sampled with start.
- a_in  input  WIDTH  first operand, unsigned, sampled with start.
- b_in  input  WIDTH  second operand, unsigned, sampled with start.
- ready  output  1  high in IDLE; reset value 1.
- done  output  1  one-cycle pulse when result is valid; reset value 0.
- result  output  WIDTH  gcd, held from done until the next accepted start; reset value 0.
- cycles  output  WIDTH  number of BUSY cycles for the last transaction, saturating at all-ones; reset value 0.

## Operation
- States are IDLE, BUSY and DONE. Reset forces IDLE from any state, including mid-operation; outputs return to their reset values.
- IDLE: ready=1. On start=1, the block loads a_in/b_in into registers a/b, latches mode, clears shift count k and the cycle counter, and moves to BUSY.
- BUSY: the cycle counter increments every cycle. One step per cycle:
  - Termination check first. In Euclid mode, terminate if a==0, b==0, or a==b; the result is a|b, or a when a==b. In binary mode, terminate if a==0 or b==0; the result is (a|b)<<k.
  - Euclid step: if a>b then a=a−b, else b=b−a.
  - Binary step, in priority order:
    - both even: a>>=1, b>>=1, k++
    - a even: a>>=1
    - b even: b>>=1
    - a≥b: a=(a−b)>>1
    - otherwise: b=(b−a)>>1
  - k width is clog2(WIDTH)+1. The final shift cannot overflow because the true gcd fits in WIDTH bits.
- Terminating cycle: register result and cycles, then go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- gcd(0,0)=0 and gcd(x,0)=gcd(0,x)=x in both modes.
- start is ignored while in BUSY or DONE. There is no queueing.
- mode, a_in and b_in are don't-care except in the cycle where start is accepted.

## Timing
- Start is accepted at edge T0. BUSY runs from T0+1 for n cycles (n = cycles). done is high during cycle T0+n+1. ready rises at T0+n+2. A new start may be accepted at the edge ending that cycle.
- Minimum latency from start to done is 2 cycles (a zero operand).
- Worst-case Euclid n = 2^WIDTH−1 for operands (2^WIDTH−1, 1). Worst-case binary n ≤ 2·WIDTH+1.
- result and cycles change only on the terminating BUSY edge or on reset.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package `gcd_pkg` holds:
  - `gcd_state_t` enum: IDLE, BUSY, DONE
  - `gcd_mode_t` enum: MODE_EUCLID=1'b0, MODE_BINARY=1'b1
- Sub-module `gcd_step` (parameter WIDTH): purely combinational. It takes a, b and mode and produces next_a, next_b, inc_k and term. `gcd_multi` holds the FSM, registers and counter.

## Test plan
- WIDTH=32, Euclid, (12,8) → result=4, cycles=3, done 4 cycles after start. Binary, (12,8) → result=4, cycles=6.
- WIDTH=32, both modes, (1071,462) → 21. (0,0) → 0 with cycles=1. (0,9) and (9,0) → 9.
- WIDTH=8, Euclid, (255,1) → result=1, cycles=255. Binary, (255,1) → result=1, cycles ≤ 17.
- Assert start every cycle during a transaction → exactly one done per accepted start, and operands from the ignored starts have no effect.
- Assert reset in the 2nd BUSY cycle of (1071,462) → next cycle ready=1, done=0, result=0, cycles=0. A following start with (6,4) → 2.
- Random regression: 10k pairs per mode at WIDTH=16 against a reference model. Check that done pulses for exactly one cycle and that result is stable until the next start.
